// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store initiator and data_mem_responder.
// Initiator drives Req/We/Addr/Size/WD. Responder returns RD/Ready/Err.
// Req and the request fields stay stable until Ready is seen.
interface data_mem_responder_if;
    logic        Req;
    logic        We;
    logic [31:0] Addr;
    logic [1:0]  Size;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        Ready;
    logic        Err;

    modport master (
        output Req, We, Addr, Size, WD,
        input  RD, Ready, Err
    );

    modport slave (
        input  Req, We, Addr, Size, WD,
        output RD, Ready, Err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Purpose : byte-addressable 32-bit data memory with byte/half/word loads and stores.
// Latency : Req sampled at edge N -> one-cycle Ready during the cycle after edge N+WAIT_CYCLES+1.
// Backpres: one transaction in flight; Req is ignored outside IDLE, the initiator holds it until Ready.
// Ports   : Clk, Rst (sync, active high); bus (slave modport) carries Req/We/Addr/Size/WD in and
//           RD/Ready/Err out. RD/Ready/Err are registered.
// Config  : define DMEM_LOAD_SIGNEXT_EN to sign-extend byte/half loads (zero-extended otherwise).
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    data_mem_responder_if.slave   bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q, rd_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    // In IDLE the live bus fields are used so a zero-wait store can commit on the
    // same edge that captures the request; elsewhere the captured copy is used.
    logic [31:0] cur_addr, cur_wd, word, load_val;
    logic [1:0]  cur_size;
    logic        cur_we, oor, misal, bad;
    logic [AW-1:0] idx;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    always_comb begin
        cur_addr = (state_q == S_IDLE) ? bus.Addr : addr_q;
        cur_wd   = (state_q == S_IDLE) ? bus.WD   : wd_q;
        cur_size = (state_q == S_IDLE) ? bus.Size : size_q;
        cur_we   = (state_q == S_IDLE) ? bus.We   : we_q;

        idx   = cur_addr[AW+1:2];
        oor   = (cur_addr[31:AW+2] != '0);
        misal = (cur_size == 2'b11) ||
                (cur_size == 2'b01 && cur_addr[0]) ||
                (cur_size == 2'b10 && cur_addr[1:0] != 2'b00);
        bad   = oor || misal;

        word = mem_q[idx];
        case (cur_addr[1:0])
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = cur_addr[1] ? word[31:16] : word[15:0];

        case (cur_size)
`ifdef DMEM_LOAD_SIGNEXT_EN
            2'b00:   load_val = {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{half_sel[15]}}, half_sel};
`else
            2'b00:   load_val = {24'd0, byte_sel};
            2'b01:   load_val = {16'd0, half_sel};
`endif
            default: load_val = word;
        endcase

        // Store data is replicated across lanes; the byte enables pick the lanes.
        case (cur_size)
            2'b00: begin
                wr_be   = 4'b0001 << cur_addr[1:0];
                wr_data = {4{cur_wd[7:0]}};
            end
            2'b01: begin
                wr_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{cur_wd[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = cur_wd;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        wd_d    = wd_q;
        rd_d    = 32'd0;
        ready_d = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Req) begin
                    addr_d = bus.Addr;
                    we_d   = bus.We;
                    size_d = bus.Size;
                    wd_d   = bus.WD;
                    cnt_d  = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        wr_en   = cur_we && !bad;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_RESP;
                    wr_en   = cur_we && !bad;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                // Response flops load here, so Ready shows in the following (IDLE) cycle.
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                ready_d = 1'b1;
                err_d   = bad;
                rd_d    = (bad || cur_we) ? 32'd0 : load_val;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            wd_q    <= 32'd0;
            rd_q    <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge Clk) begin
        if (wr_en && !Rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem_q[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign bus.RD    = rd_q;
    assign bus.Ready = ready_q;
    assign bus.Err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_CYCLES=2 instance driven from a vector table plus
// a reset-abort sequence, and a WAIT_CYCLES=0 instance driven back-to-back with Req held high.
// Expected results go into a scoreboard queue when issued and are checked when Ready appears.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rsta, rstb;
    always #5 clk = ~clk;

    data_mem_responder_if ifa ();
    data_mem_responder_if ifb ();

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut  (.Clk(clk), .Rst(rsta), .bus(ifa));
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (.Clk(clk), .Rst(rstb), .bus(ifb));

`ifdef DMEM_LOAD_SIGNEXT_EN
    localparam logic [31:0] X_A5   = 32'hFFFF_FFA5;
    localparam logic [31:0] X_8001 = 32'hFFFF_8001;
    localparam logic [31:0] X_80   = 32'hFFFF_FF80;
    localparam logic [31:0] X_A1B2 = 32'hFFFF_A1B2;
`else
    localparam logic [31:0] X_A5   = 32'h0000_00A5;
    localparam logic [31:0] X_8001 = 32'h0000_8001;
    localparam logic [31:0] X_80   = 32'h0000_0080;
    localparam logic [31:0] X_A1B2 = 32'h0000_A1B2;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One transaction on the WAIT_CYCLES=2 instance. Inputs are scrambled after the
    // request is taken to show the responder works from its captured copy.
    task automatic run_txn(input string name, input vec_t v);
        exp_t e;
        int   cyc;
        logic got;
        e.rd = v.exp_rd;
        e.err = v.exp_err;
        sbq.push_back(e);
        @(negedge clk);
        ifa.Req = 1'b1; ifa.We = v.we; ifa.Addr = v.addr; ifa.Size = v.size; ifa.WD = v.wd;
        cyc = 0;
        got = 1'b0;
        while (cyc < 20 && !got) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                ifa.Addr = v.addr ^ 32'h0000_0044;
                ifa.WD   = ~v.wd;
                ifa.We   = ~v.we;
                ifa.Size = v.size ^ 2'b01;
            end
            if (ifa.Ready) got = 1'b1;
        end
        e = sbq.pop_front();
        if (!got) begin
            check({name, " ready timeout"}, 32'd0, 32'd1);
            ifa.Req = 1'b0;
        end else begin
            ifa.Req = 1'b0;
            check({name, " latency"}, cyc, 32'd4);
            check({name, " rd"}, ifa.RD, e.rd);
            check({name, " err"}, {31'd0, ifa.Err}, {31'd0, e.err});
            @(posedge clk); #1;
            check({name, " ready width"}, {31'd0, ifa.Ready}, 32'd0);
        end
    endtask

    vec_t tbl[$];
    vec_t b2b[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   cyc, last, k, hits;

        ifa.Req = 0; ifa.We = 0; ifa.Addr = 0; ifa.Size = 0; ifa.WD = 0;
        ifb.Req = 0; ifb.We = 0; ifb.Addr = 0; ifb.Size = 0; ifb.WD = 0;
        rsta = 1'b1; rstb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset A ready", {31'd0, ifa.Ready}, 32'd0);
        check("reset A err",   {31'd0, ifa.Err},   32'd0);
        check("reset A rd",    ifa.RD,             32'd0);
        check("reset B ready", {31'd0, ifb.Ready}, 32'd0);
        check("reset B rd",    ifb.RD,             32'd0);
        @(negedge clk);
        rsta = 1'b0; rstb = 1'b0;

        //             we    addr          size   wd             exp_rd         err
        tbl.push_back('{1'b1, 32'h0000_0010, 2'b10, 32'hDEAD_BEEF, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 32'h0000_0010, 2'b10, 32'h0,         32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{1'b1, 32'h0000_0020, 2'b10, 32'h0,         32'h0,         1'b0});
        tbl.push_back('{1'b1, 32'h0000_0022, 2'b00, 32'h1234_56A5, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 32'h0000_0020, 2'b10, 32'h0,         32'h00A5_0000, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_0022, 2'b00, 32'h0,         X_A5,          1'b0});
        tbl.push_back('{1'b0, 32'h0000_0023, 2'b00, 32'h0,         32'h0,         1'b0});
        tbl.push_back('{1'b1, 32'h0000_0024, 2'b10, 32'h1122_3344, 32'h0,         1'b0});
        tbl.push_back('{1'b1, 32'h0000_0026, 2'b01, 32'hFFFF_8001, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 32'h0000_0024, 2'b10, 32'h0,         32'h8001_3344, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_0026, 2'b01, 32'h0,         X_8001,        1'b0});
        tbl.push_back('{1'b0, 32'h0000_0024, 2'b01, 32'h0,         32'h0000_3344, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_0027, 2'b00, 32'h0,         X_80,          1'b0});
        tbl.push_back('{1'b0, 32'h0000_0025, 2'b00, 32'h0,         32'h0000_0033, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_0021, 2'b10, 32'h0,         32'h0,         1'b1});
        tbl.push_back('{1'b0, 32'h0000_0023, 2'b01, 32'h0,         32'h0,         1'b1});
        tbl.push_back('{1'b0, 32'h0000_0020, 2'b11, 32'h0,         32'h0,         1'b1});
        tbl.push_back('{1'b1, 32'h0000_0000, 2'b10, 32'hCAFE_F00D, 32'h0,         1'b0});
        tbl.push_back('{1'b1, 32'h0000_0400, 2'b10, 32'hFFFF_FFFF, 32'h0,         1'b1});
        tbl.push_back('{1'b0, 32'h0000_0000, 2'b10, 32'h0,         32'hCAFE_F00D, 1'b0});
        tbl.push_back('{1'b0, 32'h8000_0000, 2'b10, 32'h0,         32'h0,         1'b1});
        tbl.push_back('{1'b1, 32'h0000_0030, 2'b10, 32'h0BAD_C0DE, 32'h0,         1'b0});

        foreach (tbl[i]) run_txn($sformatf("vec%0d", i), tbl[i]);

        // Reset on the edge that would enter RESP: the store must not land and no Ready.
        @(negedge clk);
        ifa.Req = 1'b1; ifa.We = 1'b1; ifa.Addr = 32'h30; ifa.Size = 2'b10; ifa.WD = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        ifa.Req = 1'b0;
        @(negedge clk);
        rsta = 1'b1;
        @(negedge clk);
        rsta = 1'b0;
        hits = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ifa.Ready) hits++;
        end
        check("abort no ready", hits, 32'd0);
        run_txn("abort readback", '{1'b0, 32'h30, 2'b10, 32'h0, 32'h0BAD_C0DE, 1'b0});

        // Zero wait states with Req held high: Ready every second cycle.
        b2b.push_back('{1'b1, 32'h0000_0040, 2'b10, 32'hA1B2_C3D4, 32'h0,         1'b0});
        b2b.push_back('{1'b1, 32'h0000_0041, 2'b00, 32'h0000_0077, 32'h0,         1'b0});
        b2b.push_back('{1'b0, 32'h0000_0040, 2'b10, 32'h0,         32'hA1B2_77D4, 1'b0});
        b2b.push_back('{1'b0, 32'h0000_0042, 2'b01, 32'h0,         X_A1B2,        1'b0});
        b2b.push_back('{1'b0, 32'h0000_0043, 2'b01, 32'h0,         32'h0,         1'b1});

        @(negedge clk);
        ifb.Req = 1'b1; ifb.We = b2b[0].we; ifb.Addr = b2b[0].addr; ifb.Size = b2b[0].size; ifb.WD = b2b[0].wd;
        e.rd = b2b[0].exp_rd; e.err = b2b[0].exp_err; sbq.push_back(e);
        cyc = 0; last = 0; k = 0;
        while (k < b2b.size() && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (ifb.Ready) begin
                e = sbq.pop_front();
                check($sformatf("b2b%0d rd", k), ifb.RD, e.rd);
                check($sformatf("b2b%0d err", k), {31'd0, ifb.Err}, {31'd0, e.err});
                check($sformatf("b2b%0d spacing", k), cyc - last, 32'd2);
                last = cyc;
                k++;
                if (k < b2b.size()) begin
                    ifb.We = b2b[k].we; ifb.Addr = b2b[k].addr; ifb.Size = b2b[k].size; ifb.WD = b2b[k].wd;
                    e.rd = b2b[k].exp_rd; e.err = b2b[k].exp_err; sbq.push_back(e);
                end else begin
                    ifb.Req = 1'b0;
                end
            end
        end
        ifb.Req = 1'b0;
        if (k < b2b.size()) check("b2b ready timeout", k, b2b.size());

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, the number of 32-bit storage words (power of two, 16..4096).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, the number of wait states inserted before a response (0..15).
REQ-003 SHALL use one clock and a synchronous, active-high reset, with the ports below.
REQ-004 Clk  input  1  clock; all state updates on the rising edge.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 Req  input  1  initiator request; held high with Addr/We/WD/Size stable until Ready.
REQ-007 We  input  1  1=store, 0=load.
REQ-008 Addr  input  32  byte address.
REQ-009 Size  input  2  00=byte, 01=halfword, 10=word, 11=illegal.
REQ-010 WD  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 RD  output  32  load data, registered, valid in the Ready cycle.
REQ-012 Ready  output  1  one-cycle completion pulse.
REQ-013 Err  output  1  error flag, valid only in the Ready cycle.

Function
REQ-014 SHALL implement the FSM IDLE, WAIT, RESP; IDLE->WAIT on Req=1 (IDLE->RESP when WAIT_CYCLES=0); WAIT->RESP when the wait counter reaches WAIT_CYCLES-1; RESP->IDLE unconditionally.
REQ-015 SHALL latch Addr, We, Size and WD on the IDLE->WAIT or IDLE->RESP edge; later input changes are ignored until IDLE.
REQ-016 Latency: Req first sampled high at edge N -> Ready high during the cycle after edge N+WAIT_CYCLES+1; Ready is exactly one cycle wide.
REQ-017 SHALL ignore Req in WAIT and RESP; Req high in the cycle after Ready starts a new transaction (minimum 1 idle cycle between transactions).
REQ-018 Word index SHALL be the latched Addr[31:2]; index >= DEPTH_WORDS is out of range.
REQ-019 Misalignment: half with Addr[0]=1, word with Addr[1:0]!=0, or Size=11 is an error.
REQ-020 Error (out of range or misaligned): Ready=1, Err=1, RD=0, no memory write.
REQ-021 Store SHALL commit on the edge entering RESP, writing only the addressed byte lanes: byte -> lane Addr[1:0]; half -> lanes {Addr[1],0} and {Addr[1],1}; word -> all lanes (little-endian).
REQ-022 Load SHALL select the addressed byte or half, shifted down to bit 0 and extended per REQ-028/029; a word load returns the word unchanged.
REQ-023 Store responses SHALL drive RD=0.
REQ-024 A store followed by a load to the same address SHALL return the stored data.

Reset
REQ-025 Rst=1 at an edge SHALL force IDLE, wait counter=0, Ready=0, Err=0 and RD=0, regardless of state.
REQ-026 Reset during WAIT SHALL abort the transaction with no write and no Ready; a store takes effect only if Rst=0 on the edge entering RESP.
REQ-027 Reset SHALL NOT clear storage contents; contents are undefined after power-up.

Configuration
REQ-028 With macro DMEM_LOAD_SIGNEXT_EN defined, byte and half loads SHALL be sign-extended to 32 bits.
REQ-029 Without DMEM_LOAD_SIGNEXT_EN, byte and half loads SHALL be zero-extended; all other behaviour is identical.

Verification
REQ-030 Word store then load, WAIT_CYCLES=2: store 0xDEADBEEF @0x10, then load 0x10 -> Ready 3 cycles after each Req, RD=0xDEADBEEF, Err=0.
REQ-031 Byte lanes: word 0x00000000 @0x20, store byte 0xA5 @0x22, then word load 0x20 -> RD=0x00A50000.
REQ-032 Extension: load byte @0x22 -> RD=0xFFFFFFA5 with DMEM_LOAD_SIGNEXT_EN, 0x000000A5 without it.
REQ-033 Errors: word load @0x21 -> Ready=1, Err=1, RD=0; store @ (DEPTH_WORDS*4) -> Err=1, and a readback of word 0 is unchanged.
REQ-034 Reset abort: store 0x12345678 @0x30 with Rst pulsed in WAIT -> no Ready; a later load of 0x30 returns the prior value.
REQ-035 WAIT_CYCLES=0 and back-to-back: Req held high continuously -> Ready every 2nd cycle, each transaction completes correctly.
